// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: round-robin Wishbone arbiter holding ownership for a whole cyc, with optional watchdog
module wb_arbiter_rr #(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 0,
  localparam int SEL_WIDTH = DATA_WIDTH >> 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [MASTERS-1:0][DATA_WIDTH-1:0]   m_dat_i,
  input  logic [MASTERS-1:0]                   m_cyc_i,
  input  logic [MASTERS-1:0]                   m_stb_i,
  input  logic [MASTERS-1:0]                   m_we_i,
  input  logic [MASTERS-1:0][SEL_WIDTH-1:0]    m_sel_i,
  input  logic [MASTERS-1:0][2:0]              m_cti_i,
  input  logic [MASTERS-1:0][1:0]              m_bte_i,
  output logic [DATA_WIDTH-1:0]                m_dat_o,
  output logic [MASTERS-1:0]                   m_ack_o,
  output logic [MASTERS-1:0]                   m_err_o,
  output logic [MASTERS-1:0]                   m_rty_o,
  output logic [ADDR_WIDTH-1:0]                s_adr_o,
  output logic [DATA_WIDTH-1:0]                s_dat_o,
  output logic                                 s_cyc_o,
  output logic                                 s_stb_o,
  output logic [SEL_WIDTH-1:0]                 s_sel_o,
  output logic                                 s_we_o,
  output logic [2:0]                           s_cti_o,
  output logic [1:0]                           s_bte_o,
  input  logic [DATA_WIDTH-1:0]                s_dat_i,
  input  logic                                 s_ack_i,
  input  logic                                 s_err_i,
  input  logic                                 s_rty_i,
  output logic [MASTERS-1:0]                   grant_o
);
  localparam int IW = MASTERS > 1 ? $clog2(MASTERS) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [MASTERS-1:0] grant, grant_nx;
  logic [IW-1:0] last, last_nx, win;
  logic found, take, drop, wdt_fire;
  // winner: lowest requester above last, else lowest requester overall (wrap)
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = MASTERS - 1; i >= 0; i--) if (m_cyc_i[i]) begin win = IW'(i); found = 1'b1; end
    for (int i = MASTERS - 1; i >= 0; i--) if (m_cyc_i[i] && i > int'(last)) win = IW'(i);
  end
  // next state: grant in IDLE, release when owner drops cyc
  always_comb begin
    take = state == IDLE && found;
    drop = state == BUSY && !s_cyc_o;
    state_nx = take ? BUSY : drop ? IDLE : state;
    grant_nx = take ? MASTERS'(1) << win : drop ? '0 : grant;
    last_nx = take ? win : last;
  end
  // arbiter state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= '0;
      last <= IW'(MASTERS - 1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last <= last_nx;
    end
  end
  // one-hot slave-side mux, all zeros with no owner
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    for (int i = 0; i < MASTERS; i++) if (grant[i]) begin
      s_adr_o = m_adr_i[i];
      s_dat_o = m_dat_i[i];
      s_sel_o = m_sel_i[i];
      s_we_o = m_we_i[i];
      s_cti_o = m_cti_i[i];
      s_bte_o = m_bte_i[i];
      s_cyc_o = m_cyc_i[i];
      s_stb_o = m_stb_i[i];
    end
  end
  if (TIMEOUT > 0) begin : g_wdt
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wdt;
    logic stall, term;
    assign stall = s_cyc_o & s_stb_o;
    assign term = s_ack_i | s_err_i | s_rty_i;
    assign wdt_fire = stall & ~term & (wdt == WW'(TIMEOUT));
    // count consecutive unanswered strobe cycles
    always_ff @(posedge clk_i) wdt <= (rst_i || !stall || term || wdt_fire) ? '0 : wdt + WW'(1);
  end else begin : g_nowdt
    assign wdt_fire = 1'b0;
  end
  assign m_dat_o = s_dat_i;
  assign m_ack_o = {MASTERS{s_ack_i}} & grant;
  assign m_err_o = {MASTERS{s_err_i | wdt_fire}} & grant;
  assign m_rty_o = {MASTERS{s_rty_i}} & grant;
  assign grant_o = grant;
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: random masters/slave against a queue-based round-robin reference model
module tb_wb_arbiter_rr;
  localparam int M = 4, DW = 32, AW = 32, TO = 4, SW = DW / 8, BW = AW + DW + SW + 1 + 3 + 2;
  logic clk = 1'b0, rst_i;
  always #5 clk = ~clk;
  logic [M-1:0][AW-1:0] m_adr_i;
  logic [M-1:0][DW-1:0] m_dat_i;
  logic [M-1:0] m_cyc_i, m_stb_i, m_we_i;
  logic [M-1:0][SW-1:0] m_sel_i;
  logic [M-1:0][2:0] m_cti_i;
  logic [M-1:0][1:0] m_bte_i;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [M-1:0] m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0] s_adr_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
  logic [SW-1:0] s_sel_o;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o;

  wb_arbiter_rr #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  typedef struct {
    logic [M-1:0] grant, ack, err, rty;
    logic cyc, stb;
    logic [BW-1:0] bus;
    logic [DW-1:0] dat;
  } exp_t;
  typedef struct {
    logic [M-1:0] ack, err, rty;
    logic [DW-1:0] dat;
  } term_t;
  exp_t cq[$];
  term_t tq[$];
  exp_t e, ce;
  term_t t, te;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor: every cycle compare the bus view, and pop a termination whenever one appears
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("grant", grant_o, e.grant);
      chk("s_cyc", s_cyc_o, e.cyc);
      chk("s_stb", s_stb_o, e.stb);
      chk("s_bus", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o}, e.bus);
      chk("m_dat", m_dat_o, e.dat);
    end
    if (|{m_ack_o, m_err_o, m_rty_o}) begin
      if (tq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL term: unexpected ack=%b err=%b rty=%b expected none", m_ack_o, m_err_o, m_rty_o);
      end else begin
        t = tq.pop_front();
        chk("m_ack", m_ack_o, t.ack);
        chk("m_err", m_err_o, t.err);
        chk("m_rty", m_rty_o, t.rty);
        chk("term_dat", m_dat_o, t.dat);
      end
    end
  end

  // reference model state: owner index (-1 idle), previous winner, watchdog count
  logic [M-1:0] cyc, stb;
  int beats[M];
  int owner, last, wdt, stall_left, fires, grants, cur, idx, r;
  bit rst, ack, err, rty, stall, fire, found;

  initial begin
    owner = -1; last = M - 1; wdt = 0; stall_left = 0; fires = 0; grants = 0;
    rst_i = 1'b1;
    cyc = '1;
    for (int i = 0; i < M; i++) beats[i] = $urandom_range(1, 4);
    m_cyc_i = cyc; m_stb_i = cyc; m_adr_i = '0; m_dat_i = '0; m_we_i = '0;
    m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      rst = n < 2 || $urandom_range(0, 59) == 0;
      for (int i = 0; i < M; i++) if (!cyc[i] && $urandom_range(0, 3) == 0) begin
        cyc[i] = 1'b1;
        beats[i] = $urandom_range(1, 6);
      end
      for (int i = 0; i < M; i++) begin
        stb[i] = cyc[i] && $urandom_range(0, 5) != 0;
        m_adr_i[i] = $urandom;
        m_dat_i[i] = $urandom;
        m_sel_i[i] = SW'($urandom);
        m_we_i[i] = 1'($urandom);
        m_cti_i[i] = 3'($urandom);
        m_bte_i[i] = 2'($urandom);
      end
      m_cyc_i = cyc;
      m_stb_i = stb;
      rst_i = rst;
      if (stall_left == 0 && $urandom_range(0, 29) == 0) stall_left = $urandom_range(3, 9);
      r = $urandom_range(0, 9);
      ack = stall_left == 0 && r < 5;
      err = stall_left == 0 && r == 5;
      rty = stall_left == 0 && r == 6;
      if (stall_left > 0) stall_left--;
      s_ack_i = ack; s_err_i = err; s_rty_i = rty;
      s_dat_i = $urandom;
      cur = owner;
      stall = cur >= 0 && cyc[cur] && stb[cur];
      fire = stall && !(ack || err || rty) && wdt == TO;
      if (fire) fires++;
      ce.grant = cur >= 0 ? M'(1) << cur : '0;
      ce.cyc = cur >= 0 && cyc[cur];
      ce.stb = cur >= 0 && stb[cur];
      ce.bus = cur >= 0 ? {m_adr_i[cur], m_dat_i[cur], m_sel_i[cur], m_we_i[cur], m_cti_i[cur], m_bte_i[cur]} : '0;
      ce.dat = s_dat_i;
      cq.push_back(ce);
      te.ack = ack ? ce.grant : '0;
      te.err = (err || fire) ? ce.grant : '0;
      te.rty = rty ? ce.grant : '0;
      te.dat = s_dat_i;
      if (|{te.ack, te.err, te.rty}) tq.push_back(te);
      if (rst) begin
        owner = -1; last = M - 1; wdt = 0;
      end else begin
        wdt = (!stall || ack || err || rty || fire) ? 0 : wdt + 1;
        if (cur < 0) begin
          found = 1'b0;
          for (int k = 1; k <= M; k++) begin
            idx = (last + k) % M;
            if (!found && cyc[idx]) begin found = 1'b1; owner = idx; last = idx; grants++; end
          end
        end else if (!cyc[cur]) owner = -1;
      end
      if (cur >= 0 && stb[cur]) begin
        if (ack) begin
          beats[cur]--;
          if (beats[cur] <= 0) cyc[cur] = 1'b0;
        end
        if (err || rty || fire) cyc[cur] = 1'b0;
      end
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("pending_terms", tq.size(), 0);
    chk("wdt_fired", fires > 0, 1);
    chk("grants_seen", grants > 20, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
